// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit with HI/LO result registers.
//                MULT/MULTU use a shift-add loop, DIV/DIVU a restoring loop on
//                operand magnitudes; signs are fixed up in a final cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 is_div_q, is_div_d;
  logic                 negq_q, negq_d;     // negate product / quotient
  logic                 negr_q, negr_d;     // negate remainder (sign of a)
  logic                 divz_q, divz_d;     // divide by zero
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // product, or dividend/quotient in low half
  logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder (always < divisor)

  logic                 w_signed;
  logic                 w_sa, w_sb;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [2*WIDTH-1:0]   w_prod;

  // Operand magnitudes and per-iteration arithmetic
  always_comb begin
    w_signed  = ~op_i[0];
    w_sa      = w_signed & a_i[WIDTH-1];
    w_sb      = w_signed & b_i[WIDTH-1];
    w_abs_a   = w_sa ? (-a_i) : a_i;
    w_abs_b   = w_sb ? (-b_i) : b_i;
    // Multiply step: add multiplicand to upper half when the current bit is set
    w_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Divide step: the WIDTH+1 bit trial remainder brings in the next dividend bit
    w_trial   = {rem_q, acc_q[WIDTH-1]};
    w_ge      = (w_trial >= {1'b0, opnd_q});
    // When trial >= divisor the difference is below the divisor, so WIDTH bits suffice
    w_rem_sub = w_trial[WIDTH-1:0] - opnd_q;
    w_prod    = negq_q ? (-acc_q) : acc_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)          state_d = S_RUN;
      S_RUN:   if (count_q == LAST)  state_d = S_FIX;
      S_FIX:                         state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-state
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    divz_d   = divz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        // MTHI/MTLO only land while idle; a following FIX overwrites them
        if (hi_we_i) hi_d = wd_i;
        if (lo_we_i) lo_d = wd_i;
        if (start_i) begin
          busy_d   = 1'b1;
          count_d  = '0;
          is_div_d = op_i[1];
          negq_d   = w_sa ^ w_sb;
          negr_d   = w_sa;
          divz_d   = op_i[1] & (b_i == '0);
          rem_d    = '0;
          if (op_i[1]) begin
            opnd_d = w_abs_b;
            acc_d  = {{WIDTH{1'b0}}, w_abs_a};
          end else begin
            opnd_d = w_abs_a;
            acc_d  = {{WIDTH{1'b0}}, w_abs_b};
          end
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        if (is_div_q) begin
          rem_d = w_ge ? w_rem_sub : w_trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_ge};
        end else begin
          acc_d = {w_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (is_div_q) begin
          // With a zero divisor the remainder walks out as |a|, so the sign fix returns a
          hi_d = negr_q ? (-rem_q) : rem_q;
          lo_d = divz_q ? {WIDTH{1'b1}}
                        : (negq_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      divz_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      divz_q   <= divz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire
